// File: rtl/instr_encoder_pkg.sv
// ============================================================================
// Module   : instr_encoder_pkg
// Brief    : Mnemonic enum, MIPS opcode/funct constants and error codes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encoder_pkg;

    typedef enum logic [4:0] {
        MN_ADDU = 5'd0,  MN_SUBU = 5'd1,  MN_SLT  = 5'd2,  MN_SLTU = 5'd3,
        MN_SLLV = 5'd4,  MN_SLL  = 5'd5,  MN_JR   = 5'd6,  MN_ORI  = 5'd7,
        MN_LUI  = 5'd8,  MN_LW   = 5'd9,  MN_SW   = 5'd10, MN_LB   = 5'd11,
        MN_SB   = 5'd12, MN_LH   = 5'd13, MN_SH   = 5'd14, MN_BEQ  = 5'd15,
        MN_J    = 5'd16, MN_JAL  = 5'd17, MN_LHSO = 5'd18
    } mnem_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_LB    = 6'h20;
    localparam logic [5:0] c_OP_SB    = 6'h28;
    localparam logic [5:0] c_OP_LH    = 6'h21;
    localparam logic [5:0] c_OP_SH    = 6'h29;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_LHSO  = 6'h27;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;

    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;
    localparam logic [5:0] c_FN_SLLV  = 6'h04;
    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_JR    = 6'h08;

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'd2;

    function automatic logic [31:0] f_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [4:0] shamt,
                                            input logic [5:0] funct);
        return {c_OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] f_itype(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Instruction input stream plus acknowledged IM write port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        im_ack;

    // Master is the host/IM side, slave is the encoder.
    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        output im_ack,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
        input  im_ack,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// Module   : instr_pack
// Brief    : Combinational mnemonic + fields to 32-bit MIPS word packer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pack
    import instr_encoder_pkg::*;
(
    input  wire logic [4:0]  mnem,
    input  wire logic [4:0]  rs,
    input  wire logic [4:0]  rt,
    input  wire logic [4:0]  rd,
    input  wire logic [4:0]  shamt,
    input  wire logic [15:0] imm,
    input  wire logic [25:0] target,
    output logic      [31:0] word,
    output logic             illegal
);

    // Fields a format does not use are tied to zero, not passed through.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADDU: word = f_rtype(rs, rt, rd, 5'd0, c_FN_ADDU);
            MN_SUBU: word = f_rtype(rs, rt, rd, 5'd0, c_FN_SUBU);
            MN_SLT:  word = f_rtype(rs, rt, rd, 5'd0, c_FN_SLT);
            MN_SLTU: word = f_rtype(rs, rt, rd, 5'd0, c_FN_SLTU);
            MN_SLLV: word = f_rtype(rs, rt, rd, 5'd0, c_FN_SLLV);
            MN_SLL:  word = f_rtype(5'd0, rt, rd, shamt, c_FN_SLL);
            MN_JR:   word = f_rtype(rs, 5'd0, 5'd0, 5'd0, c_FN_JR);
            MN_ORI:  word = f_itype(c_OP_ORI, rs, rt, imm);
            MN_LUI:  word = f_itype(c_OP_LUI, 5'd0, rt, imm);
            MN_LW:   word = f_itype(c_OP_LW, rs, rt, imm);
            MN_SW:   word = f_itype(c_OP_SW, rs, rt, imm);
            MN_LB:   word = f_itype(c_OP_LB, rs, rt, imm);
            MN_SB:   word = f_itype(c_OP_SB, rs, rt, imm);
            MN_LH:   word = f_itype(c_OP_LH, rs, rt, imm);
            MN_SH:   word = f_itype(c_OP_SH, rs, rt, imm);
            MN_BEQ:  word = f_itype(c_OP_BEQ, rs, rt, imm);
            MN_LHSO: word = f_itype(c_OP_LHSO, rs, rt, imm);
            MN_J:    word = {c_OP_J, target};
            MN_JAL:  word = {c_OP_JAL, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs symbolic instructions and writes them to consecutive IM words
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          IM_AW     = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic           start,
    instr_encoder_if.slave      bus,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code,
    output logic [IM_AW:0]      count
);

    localparam logic [IM_AW:0] c_CAPACITY = {1'b1, {IM_AW{1'b0}}};
    localparam logic [IM_AW:0] c_ONE      = {{IM_AW{1'b0}}, 1'b1};

    state_e          r_state, w_state_nx;
    logic [IM_AW:0]  r_count, w_count_nx;
    logic [1:0]      r_err,   w_err_nx;
    logic [31:0]     r_wdata, w_wdata_nx;
    logic            r_last,  w_last_nx;
    logic [31:0]     w_word;
    logic            w_illegal;
    logic            w_accept;

    instr_pack u_pack (
        .mnem    (bus.in_mnem),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .rd      (bus.in_rd),
        .shamt   (bus.in_shamt),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (w_word),
        .illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_err   <= c_ERR_NONE;
            r_wdata <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_err   <= w_err_nx;
            r_wdata <= w_wdata_nx;
            r_last  <= w_last_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_err_nx   = r_err;
        w_wdata_nx = r_wdata;
        w_last_nx  = r_last;
        w_accept   = bus.in_valid && (r_state == ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_count_nx = '0;
                    w_err_nx   = c_ERR_NONE;
                end
                if (w_accept) begin
                    if (w_illegal) begin
                        w_err_nx   = c_ERR_ILLEGAL;
                        w_state_nx = ST_ERR;
                    end else begin
                        w_wdata_nx = w_word;
                        w_last_nx  = bus.in_last;
                        w_state_nx = ST_WRITE;
                    end
                end
            end
            // start is deliberately not looked at while a write is outstanding.
            ST_WRITE: begin
                if (bus.im_ack) begin
                    w_count_nx = r_count + c_ONE;
                    if (r_last) begin
                        w_state_nx = ST_DONE;
                    end else if (w_count_nx == c_CAPACITY) begin
                        w_err_nx   = c_ERR_OVERFLOW;
                        w_state_nx = ST_ERR;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                if (start) begin
                    w_count_nx = '0;
                    w_err_nx   = c_ERR_NONE;
                    w_state_nx = ST_IDLE;
                end
            end
        endcase
    end

    // im_we is decoded from state so an async reset drops it immediately.
    assign bus.in_ready = (r_state == ST_IDLE);
    assign bus.im_we    = (r_state == ST_WRITE);
    assign bus.im_wdata = r_wdata;
    assign bus.im_addr  = BASE_ADDR + {{(29 - IM_AW){1'b0}}, r_count, 2'b00};
    assign busy         = (r_state == ST_WRITE);
    assign done         = (r_state == ST_DONE);
    assign err_code     = r_err;
    assign count        = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed bench for instr_encoder (default config and IM_AW=2)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel;
    logic        t_start, t_valid, t_last, t_ack;
    logic [4:0]  t_mnem, t_rs, t_rt, t_rd, t_sh;
    logic [15:0] t_imm;
    logic [25:0] t_tgt;

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder_if ifa ();
    instr_encoder_if ifb ();

    logic        busy_a, done_a, busy_b, done_b;
    logic [1:0]  err_a, err_b;
    logic [12:0] count_a;
    logic [2:0]  count_b;

    assign ifa.in_valid  = t_valid & ~sel;
    assign ifb.in_valid  = t_valid & sel;
    assign ifa.im_ack    = t_ack & ~sel;
    assign ifb.im_ack    = t_ack & sel;
    assign ifa.in_mnem   = t_mnem;  assign ifb.in_mnem   = t_mnem;
    assign ifa.in_rs     = t_rs;    assign ifb.in_rs     = t_rs;
    assign ifa.in_rt     = t_rt;    assign ifb.in_rt     = t_rt;
    assign ifa.in_rd     = t_rd;    assign ifb.in_rd     = t_rd;
    assign ifa.in_shamt  = t_sh;    assign ifb.in_shamt  = t_sh;
    assign ifa.in_imm    = t_imm;   assign ifb.in_imm    = t_imm;
    assign ifa.in_target = t_tgt;   assign ifb.in_target = t_tgt;
    assign ifa.in_last   = t_last;  assign ifb.in_last   = t_last;

    instr_encoder #(.IM_AW(12), .BASE_ADDR(32'h0000_3000)) u_dut_a (
        .clk      (clk),
        .reset_n  (rst_a),
        .start    (t_start & ~sel),
        .bus      (ifa),
        .busy     (busy_a),
        .done     (done_a),
        .err_code (err_a),
        .count    (count_a)
    );

    instr_encoder #(.IM_AW(2), .BASE_ADDR(32'h0000_3000)) u_dut_b (
        .clk      (clk),
        .reset_n  (rst_b),
        .start    (t_start & sel),
        .bus      (ifb),
        .busy     (busy_b),
        .done     (done_b),
        .err_code (err_b),
        .count    (count_b)
    );

    logic [31:0] o_ready, o_we, o_addr, o_wdata, o_busy, o_done, o_err, o_count;
    assign o_ready = {31'd0, sel ? ifb.in_ready : ifa.in_ready};
    assign o_we    = {31'd0, sel ? ifb.im_we    : ifa.im_we};
    assign o_addr  = sel ? ifb.im_addr  : ifa.im_addr;
    assign o_wdata = sel ? ifb.im_wdata : ifa.im_wdata;
    assign o_busy  = {31'd0, sel ? busy_b : busy_a};
    assign o_done  = {31'd0, sel ? done_b : done_a};
    assign o_err   = {30'd0, sel ? err_b  : err_a};
    assign o_count = sel ? {29'd0, count_b} : {19'd0, count_a};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
    endtask

    task automatic set_fields(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                              input logic [25:0] tgt, input logic last);
        t_mnem = mn; t_rs = rs; t_rt = rt; t_rd = rd; t_sh = sh;
        t_imm = imm; t_tgt = tgt; t_last = last;
    endtask

    // One full transaction: accept, optional ack wait states, ack.
    task automatic send(input string tag, input logic [4:0] mn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                        input int ack_dly, input logic start_w_ack,
                        input logic [31:0] exp_word, input logic [31:0] exp_addr);
        set_fields(mn, rs, rt, rd, sh, imm, tgt, last);
        t_valid = 1'b1;
        for (int k = 0; k < 20 && o_ready[0] !== 1'b1; k++) tick();
        if (o_ready[0] !== 1'b1) begin
            check({tag, "_ready_timeout"}, o_ready, 32'd1);
            t_valid = 1'b0;
            return;
        end
        tick();
        t_valid = 1'b0;
        check({tag, "_we"},    o_we,    32'd1);
        check({tag, "_busy"},  o_busy,  32'd1);
        check({tag, "_wdata"}, o_wdata, exp_word);
        check({tag, "_addr"},  o_addr,  exp_addr);
        for (int k = 0; k < ack_dly; k++) begin
            tick();
            check({tag, "_hold_we"},    o_we,    32'd1);
            check({tag, "_hold_wdata"}, o_wdata, exp_word);
            check({tag, "_hold_addr"},  o_addr,  exp_addr);
        end
        t_ack   = 1'b1;
        t_start = start_w_ack;
        tick();
        t_ack   = 1'b0;
        t_start = 1'b0;
        check({tag, "_we_off"}, o_we, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; t_start = 1'b0; t_valid = 1'b0; t_ack = 1'b0;
        set_fields(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) tick();
        rst_a = 1'b1; rst_b = 1'b1;
        tick();

        check("rst_ready", o_ready, 32'd1);
        check("rst_we",    o_we,    32'd0);
        check("rst_wdata", o_wdata, 32'd0);
        check("rst_addr",  o_addr,  32'h0000_3000);
        check("rst_count", o_count, 32'd0);
        check("rst_err",   o_err,   32'd0);
        check("rst_busy",  o_busy,  32'd0);
        check("rst_done",  o_done,  32'd0);

        send("addu", MN_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0, 0, 1'b0,
             32'h0022_1821, 32'h0000_3000);
        check("addu_count", o_count, 32'd1);
        check("addu_ready_next", o_ready, 32'd1);
        check("addu_addr_next",  o_addr,  32'h0000_3004);
        pulse_start();
        check("start_count", o_count, 32'd0);

        send("ori", MN_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0, 0, 1'b0,
             32'h3401_1234, 32'h0000_3000);
        send("lui", MN_LUI, 5'd9, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0, 0, 1'b0,
             32'h3C01_FFFF, 32'h0000_3004);
        check("lui_count", o_count, 32'd2);
        pulse_start();

        send("sll", MN_SLL, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0, 26'd0, 1'b0, 0, 1'b0,
             32'h0003_1100, 32'h0000_3000);
        send("sw", MN_SW, 5'd29, 5'd2, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0, 3, 1'b0,
             32'hAFA2_0004, 32'h0000_3004);
        send("lhso", MN_LHSO, 5'd4, 5'd5, 5'd0, 5'd0, 16'd8, 26'd0, 1'b1, 0, 1'b0,
             32'h9C85_0008, 32'h0000_3008);
        check("lhso_done",  o_done,  32'd1);
        check("lhso_ready", o_ready, 32'd0);
        check("lhso_busy",  o_busy,  32'd0);
        check("lhso_count", o_count, 32'd3);

        t_ack = 1'b1;
        tick();
        t_ack = 1'b0;
        check("stray_ack_count", o_count, 32'd3);
        check("stray_ack_done",  o_done,  32'd1);

        pulse_start();
        check("restart_count", o_count, 32'd0);
        check("restart_ready", o_ready, 32'd1);
        check("restart_done",  o_done,  32'd0);

        set_fields(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        check("illegal_err",   o_err,   32'd1);
        check("illegal_we",    o_we,    32'd0);
        check("illegal_count", o_count, 32'd0);
        check("illegal_ready", o_ready, 32'd0);
        tick();
        check("illegal_sticky", o_err, 32'd1);
        pulse_start();
        check("illegal_clear", o_err, 32'd0);

        // start coincident with the ack must be dropped, so count ends at 1.
        send("jal", MN_JAL, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h000C00, 1'b0, 0, 1'b1,
             32'h0C00_0C00, 32'h0000_3000);
        check("jal_count", o_count, 32'd1);
        check("jal_ready", o_ready, 32'd1);

        sel = 1'b1;
        tick();
        send("b_addu", MN_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0, 0, 1'b0,
             32'h0022_1821, 32'h0000_3000);
        send("b_subu", MN_SUBU, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0, 1'b0, 0, 1'b0,
             32'h0022_1823, 32'h0000_3004);
        send("b_jr", MN_JR, 5'd1, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0, 1'b0, 1, 1'b0,
             32'h0020_0008, 32'h0000_3008);
        send("b_slt", MN_SLT, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0, 0, 1'b0,
             32'h0022_182A, 32'h0000_300C);
        check("ovf_err",   o_err,   32'd2);
        check("ovf_ready", o_ready, 32'd0);
        check("ovf_count", o_count, 32'd4);
        check("ovf_busy",  o_busy,  32'd0);

        set_fields(MN_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        t_valid = 1'b1;
        repeat (3) tick();
        t_valid = 1'b0;
        check("ovf_fifth_we",    o_we,    32'd0);
        check("ovf_fifth_count", o_count, 32'd4);

        pulse_start();
        check("ovf_clear_err",   o_err,   32'd0);
        check("ovf_clear_ready", o_ready, 32'd1);

        t_valid = 1'b1;
        tick();
        t_valid = 1'b0;
        check("rstmid_we_before", o_we, 32'd1);
        rst_b = 1'b0;
        #1;
        check("rstmid_we",    o_we,    32'd0);
        check("rstmid_busy",  o_busy,  32'd0);
        check("rstmid_count", o_count, 32'd0);
        tick();
        rst_b = 1'b1;
        tick();
        check("rstmid_ready", o_ready, 32'd1);
        check("rstmid_addr",  o_addr,  32'h0000_3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
